lcd_char_writer: RTL

Paced write engine for an HD44780-compatible character LCD in 8-bit, write-only mode. It sits directly downstream of the 40 µs tick counter and consumes its one-cycle `Cuenta` pulse as `Tick`. After reset it runs the power-up initialisation sequence, then accepts one command or data byte at a time from the host through a valid/ready handshake. It drives `RS`, `RW`, `E` and `DB` with HD44780 setup, enable and execution timing, all counted in ticks.

---
 rtl/lcd_char_writer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/lcd_char_writer.sv
// Paced HD44780 write engine (8-bit, write-only): runs the power-up init
// sequence, then writes one host command/data byte per Valid/Ready handshake.
module lcd_char_writer #(
  parameter int unsigned POWERUP_TICKS = 375,
  parameter int unsigned LONG_TICKS    = 103,
  parameter int unsigned SHORT_TICKS   = 3,
  parameter int unsigned CLEAR_TICKS   = 41
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       Valid,
  input  logic       RS_In,
  input  logic [7:0] Data_In,
  output logic       Ready,
  output logic       Init_Done,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] LCD_DB,
  output logic [2:0] Dbg_State
);

  localparam logic [9:0] PWR_W   = 10'(POWERUP_TICKS);
  localparam logic [9:0] LONG_W  = 10'(LONG_TICKS);
  localparam logic [9:0] SHORT_W = 10'(SHORT_TICKS);
  localparam logic [9:0] CLEAR_W = 10'(CLEAR_TICKS);

  typedef enum logic [2:0] {
    S_PWR_WAIT = 3'd0,
    S_SETUP    = 3'd1,
    S_E_HIGH   = 3'd2,
    S_HOLD     = 3'd3,
    S_WAIT     = 3'd4,
    S_IDLE     = 3'd5
  } state_t;

  state_t     state, state_n;
  logic [9:0] cnt, cnt_n;
  logic [2:0] step, step_n;
  logic       clr_cmd, clr_n;
  logic       ready_n, done_n, rs_n, e_n;
  logic [7:0] db_n;
  logic       accept, adv;
  logic [9:0] wait_d;

  function automatic logic [7:0] init_byte(input logic [2:0] s);
    case (s)
      3'd4:    init_byte = 8'h08;
      3'd5:    init_byte = 8'h01;
      3'd6:    init_byte = 8'h06;
      3'd7:    init_byte = 8'h0C;
      default: init_byte = 8'h38;
    endcase
  endfunction

  function automatic logic [9:0] init_wait(input logic [2:0] s);
    case (s)
      3'd0:    init_wait = LONG_W;
      3'd1:    init_wait = SHORT_W;
      3'd5:    init_wait = CLEAR_W;
      default: init_wait = 10'd0;
    endcase
  endfunction

  // Handshake: a byte is taken on any clock where Valid & Ready are both 1,
  // regardless of Tick; Ready stays low until that write fully completes,
  // and Valid while Ready=0 is simply ignored.
  assign accept = (state == S_IDLE) && Valid && Ready;
  assign wait_d = Init_Done ? (clr_cmd ? CLEAR_W : 10'd0) : init_wait(step);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_PWR_WAIT;
      cnt       <= PWR_W;
      step      <= 3'd0;
      clr_cmd   <= 1'b0;
      Ready     <= 1'b0;
      Init_Done <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_E     <= 1'b0;
      LCD_DB    <= 8'h00;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      step      <= step_n;
      clr_cmd   <= clr_n;
      Ready     <= ready_n;
      Init_Done <= done_n;
      LCD_RS    <= rs_n;
      LCD_E     <= e_n;
      LCD_DB    <= db_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    step_n  = step;
    adv     = 1'b0;
    case (state)
      S_PWR_WAIT: if (Tick) begin
        if (cnt == 10'd1) begin
          state_n = S_SETUP;
          step_n  = 3'd0;
        end else begin
          cnt_n = cnt - 10'd1;
        end
      end
      S_SETUP:  if (Tick) state_n = S_E_HIGH;
      S_E_HIGH: if (Tick) state_n = S_HOLD;
      S_HOLD: if (Tick) begin
        if (wait_d != 10'd0) begin
          state_n = S_WAIT;
          cnt_n   = wait_d;
        end else begin
          adv = 1'b1;
        end
      end
      S_WAIT: if (Tick) begin
        if (cnt == 10'd1) adv = 1'b1;
        else cnt_n = cnt - 10'd1;
      end
      S_IDLE: if (accept) state_n = S_SETUP;
      default: state_n = S_PWR_WAIT;
    endcase
    // End of a write cycle: next init step, or back to idle.
    if (adv) begin
      if (!Init_Done && step != 3'd7) begin
        state_n = S_SETUP;
        step_n  = step + 3'd1;
      end else begin
        state_n = S_IDLE;
      end
    end
  end

  always_comb begin
    ready_n = (state_n == S_IDLE);
    done_n  = Init_Done | (state_n == S_IDLE);
    e_n     = (state_n == S_E_HIGH);
    rs_n    = LCD_RS;
    db_n    = LCD_DB;
    clr_n   = clr_cmd;
    if (accept) begin
      rs_n  = RS_In;
      db_n  = Data_In;
      clr_n = !RS_In && (Data_In[7:2] == 6'd0) && (Data_In[1:0] != 2'd0);
    end else if (!Init_Done && state_n == S_SETUP && state != S_SETUP) begin
      rs_n = 1'b0;
      db_n = init_byte(step_n);
    end
  end

  assign LCD_RW    = 1'b0;
  assign Dbg_State = state;

endmodule
